// File: rtl/sa_operand_feeder.sv
// Operand feeder for the 3x3 systolic array: ping-pong buffers A/B pairs and
// replays each pair as diagonally skewed row/column streams with a start level.

module sa_feeder_lane #(
  parameter int DW   = 8,
  parameter int LANE = 0
) (
  input  logic                 en,
  input  logic [2:0]           ph,
  input  logic [2:0][DW-1:0]   a_vals,
  input  logic [2:0][DW-1:0]   b_vals,
  output logic [DW-1:0]        x_nxt,
  output logic [DW-1:0]        y_nxt
);
  logic [3:0] k;

  // k wraps above 2 when ph < LANE, so a single bound check covers the window
  always_comb begin
    k     = {1'b0, ph} - 4'(LANE);
    x_nxt = '0;
    y_nxt = '0;
    if (en && k <= 4'd2) begin
      x_nxt = a_vals[k[1:0]];
      y_nxt = b_vals[k[1:0]];
    end
  end
endmodule

module sa_operand_feeder #(
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_a0,
  input  logic signed [DW-1:0] in_a1,
  input  logic signed [DW-1:0] in_a2,
  input  logic signed [DW-1:0] in_b0,
  input  logic signed [DW-1:0] in_b1,
  input  logic signed [DW-1:0] in_b2,
  input  logic                 abort,
  output logic signed [DW-1:0] x_1,
  output logic signed [DW-1:0] x_2,
  output logic signed [DW-1:0] x_3,
  output logic signed [DW-1:0] y_1,
  output logic signed [DW-1:0] y_2,
  output logic signed [DW-1:0] y_3,
  output logic                 start_o,
  output logic [2:0]           phase,
  output logic                 job_last,
  output logic [1:0]           banks_full
);
  localparam int NUM_LANES = 3;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // [bank][beat k][lane]: mem_a holds A[lane][k], mem_b holds B[k][lane]
  logic [1:0][NUM_LANES-1:0][NUM_LANES-1:0][DW-1:0] mem_a, mem_b;

  logic [1:0]                     full, full_n;
  logic                           wptr, rptr, rptr_n;
  logic [1:0]                     beat_cnt;
  state_t                         state_q, state_n;
  logic                           start_q, start_n;
  logic [2:0]                     phase_q, phase_n;
  logic [NUM_LANES-1:0][DW-1:0]   x_q, y_q, x_nxt, y_nxt;

  logic accept, last_beat, other_ready, rd_done, sel_bank, stream_en;

  assign in_ready    = !full[wptr] && !abort;
  assign accept      = in_valid && in_ready;
  assign last_beat   = accept && (beat_cnt == 2'd2);
  // a bank completing on this same edge counts as ready for gapless handoff
  assign other_ready = full[~rptr] || (last_beat && (wptr != rptr));

  always_comb begin
    state_n   = state_q;
    start_n   = start_q;
    phase_n   = 3'd0;
    rptr_n    = rptr;
    rd_done   = 1'b0;
    sel_bank  = rptr;
    stream_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full[rptr]) begin
          state_n   = S_RUN;
          start_n   = 1'b1;
          stream_en = 1'b1;
        end
      end
      S_RUN: begin
        if (phase_q != 3'd7) begin
          phase_n   = phase_q + 3'd1;
          stream_en = 1'b1;
        end else begin
          rd_done = 1'b1;
          rptr_n  = ~rptr;
          if (other_ready) begin
            sel_bank  = ~rptr;
            stream_en = 1'b1;
          end else begin
            state_n = S_IDLE;
            start_n = 1'b0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    full_n = full;
    if (rd_done)   full_n[rptr] = 1'b0;
    if (last_beat) full_n[wptr] = 1'b1;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [2:0][DW-1:0] av, bv;
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_beat
      assign av[k] = mem_a[sel_bank][k][g];
      assign bv[k] = mem_b[sel_bank][k][g];
    end
    sa_feeder_lane #(.DW(DW), .LANE(g)) u_lane (
      .en     (stream_en),
      .ph     (phase_n),
      .a_vals (av),
      .b_vals (bv),
      .x_nxt  (x_nxt[g]),
      .y_nxt  (y_nxt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      beat_cnt <= '0;
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      phase_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (abort) begin
      full     <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      beat_cnt <= '0;
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      phase_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      full    <= full_n;
      rptr    <= rptr_n;
      state_q <= state_n;
      start_q <= start_n;
      phase_q <= phase_n;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      if (accept) begin
        beat_cnt <= last_beat ? 2'd0 : beat_cnt + 2'd1;
        if (last_beat) wptr <= ~wptr;
      end
    end
  end

  // operand storage needs no reset: a bank is only read once its full flag is set
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_a[wptr][beat_cnt] <= {in_a2, in_a1, in_a0};
      mem_b[wptr][beat_cnt] <= {in_b2, in_b1, in_b0};
    end
  end

  assign x_1        = x_q[0];
  assign x_2        = x_q[1];
  assign x_3        = x_q[2];
  assign y_1        = y_q[0];
  assign y_2        = y_q[1];
  assign y_3        = y_q[2];
  assign start_o    = start_q;
  assign phase      = phase_q;
  assign job_last   = start_q && (phase_q == 3'd7);
  assign banks_full = full;
endmodule
